// File: rtl/ex.sv
// Execute stage of the scalar LoongArch pipeline: single-cycle logic/shift/arith/mul
// plus an iterative radix-2 restoring divider that stalls the pipeline via pause_ex.
package ex_pkg;
  localparam int unsigned ALU_OP_W  = 8;
  localparam int unsigned ALU_SEL_W = 3;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 5;

  localparam logic [ALU_OP_W-1:0] ALU_NOP    = 8'h00;
  localparam logic [ALU_OP_W-1:0] ALU_OR     = 8'h01;
  localparam logic [ALU_OP_W-1:0] ALU_ORI    = 8'h02;
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 8'h03;
  localparam logic [ALU_OP_W-1:0] ALU_NOR    = 8'h04;
  localparam logic [ALU_OP_W-1:0] ALU_XOR    = 8'h05;
  localparam logic [ALU_OP_W-1:0] ALU_SLLW   = 8'h06;
  localparam logic [ALU_OP_W-1:0] ALU_SRLW   = 8'h07;
  localparam logic [ALU_OP_W-1:0] ALU_SRAW   = 8'h08;
  localparam logic [ALU_OP_W-1:0] ALU_ADDW   = 8'h09;
  localparam logic [ALU_OP_W-1:0] ALU_SUBW   = 8'h0A;
  localparam logic [ALU_OP_W-1:0] ALU_SLT    = 8'h0B;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 8'h0C;
  localparam logic [ALU_OP_W-1:0] ALU_MULW   = 8'h0D;
  localparam logic [ALU_OP_W-1:0] ALU_MULHW  = 8'h0E;
  localparam logic [ALU_OP_W-1:0] ALU_MULHWU = 8'h0F;
  localparam logic [ALU_OP_W-1:0] ALU_DIVW   = 8'h10;
  localparam logic [ALU_OP_W-1:0] ALU_MODW   = 8'h11;
  localparam logic [ALU_OP_W-1:0] ALU_DIVWU  = 8'h12;
  localparam logic [ALU_OP_W-1:0] ALU_MODWU  = 8'h13;

  localparam logic [ALU_SEL_W-1:0] ALU_SEL_NOP   = 3'd0;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_LOGIC = 3'd1;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_SHIFT = 3'd2;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_ARITH = 3'd3;
endpackage

module ex
  import ex_pkg::*;
#(
  parameter int unsigned DIV_ITER = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic [ALU_OP_W-1:0]  aluop_i,
  input  logic [ALU_SEL_W-1:0] alusel_i,
  input  logic [DATA_W-1:0]    reg1_i,
  input  logic [DATA_W-1:0]    reg2_i,
  input  logic [ADDR_W-1:0]    reg_write_addr_i,
  input  logic                 reg_write_en_i,
  output logic [DATA_W-1:0]    reg_write_data_o,
  output logic [ADDR_W-1:0]    reg_write_addr_o,
  output logic                 reg_write_en_o,
  output logic                 pause_ex
);

  localparam int unsigned CNT_W  = $clog2(DIV_ITER);
  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] x);
    return ~x + DATA_W'(1);
  endfunction

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quot_q, quot_d;
  logic [DATA_W-1:0]   div_q, div_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic                is_mod_q, is_mod_d;
  logic                zero_q, zero_d;

  logic                is_div_c, is_signed_c, is_mod_c, a_neg_c, b_neg_c, pause_c;
  logic [4:0]          sh_c;
  logic [PROD_W-1:0]   prod_s_c, prod_u_c;
  logic [DATA_W:0]     trial_c, diff_c;
  logic [DATA_W-1:0]   logic_res_c, shift_res_c, arith_res_c, div_res_c, result_c;

  assign is_div_c    = (aluop_i == ALU_DIVW) || (aluop_i == ALU_MODW) ||
                       (aluop_i == ALU_DIVWU) || (aluop_i == ALU_MODWU);
  assign is_signed_c = (aluop_i == ALU_DIVW) || (aluop_i == ALU_MODW);
  assign is_mod_c    = (aluop_i == ALU_MODW) || (aluop_i == ALU_MODWU);
  assign a_neg_c     = is_signed_c & reg1_i[DATA_W-1];
  assign b_neg_c     = is_signed_c & reg2_i[DATA_W-1];
  assign sh_c        = reg2_i[4:0];

  // Low 64 bits of a product of sign-/zero-extended operands give the exact result.
  assign prod_s_c = {{DATA_W{reg1_i[DATA_W-1]}}, reg1_i} * {{DATA_W{reg2_i[DATA_W-1]}}, reg2_i};
  assign prod_u_c = {{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i};

  always_comb begin
    logic_res_c = '0;
    case (aluop_i)
      ALU_OR, ALU_ORI: logic_res_c = reg1_i | reg2_i;
      ALU_AND:         logic_res_c = reg1_i & reg2_i;
      ALU_NOR:         logic_res_c = ~(reg1_i | reg2_i);
      ALU_XOR:         logic_res_c = reg1_i ^ reg2_i;
      default:         logic_res_c = '0;
    endcase
  end

  always_comb begin
    shift_res_c = '0;
    case (aluop_i)
      ALU_SLLW: shift_res_c = reg1_i << sh_c;
      ALU_SRLW: shift_res_c = reg1_i >> sh_c;
      ALU_SRAW: shift_res_c = $unsigned($signed(reg1_i) >>> sh_c);
      default:  shift_res_c = '0;
    endcase
  end

  // Divider result is only meaningful in DONE; zero-divisor results were stored raw.
  always_comb begin
    div_res_c = '0;
    if (zero_q) begin
      div_res_c = is_mod_q ? rem_q : quot_q;
    end else if (is_mod_q) begin
      div_res_c = r_neg_q ? neg(rem_q) : rem_q;
    end else begin
      div_res_c = q_neg_q ? neg(quot_q) : quot_q;
    end
  end

  always_comb begin
    arith_res_c = '0;
    case (aluop_i)
      ALU_ADDW:   arith_res_c = reg1_i + reg2_i;
      ALU_SUBW:   arith_res_c = reg1_i - reg2_i;
      ALU_SLT:    arith_res_c = DATA_W'($signed(reg1_i) < $signed(reg2_i));
      ALU_SLTU:   arith_res_c = DATA_W'(reg1_i < reg2_i);
      ALU_MULW:   arith_res_c = prod_u_c[DATA_W-1:0];
      ALU_MULHW:  arith_res_c = prod_s_c[PROD_W-1:DATA_W];
      ALU_MULHWU: arith_res_c = prod_u_c[PROD_W-1:DATA_W];
      ALU_DIVW, ALU_MODW, ALU_DIVWU, ALU_MODWU:
                  arith_res_c = (state_q == S_DONE) ? div_res_c : '0;
      default:    arith_res_c = '0;
    endcase
  end

  always_comb begin
    result_c = '0;
    case (alusel_i)
      ALU_SEL_LOGIC: result_c = logic_res_c;
      ALU_SEL_SHIFT: result_c = shift_res_c;
      ALU_SEL_ARITH: result_c = arith_res_c;
      default:       result_c = '0;
    endcase
  end

  assign trial_c = {rem_q, quot_q[DATA_W-1]};
  assign diff_c  = trial_c - {1'b0, div_q};

  // Divider next-state: capture in IDLE, one restoring step per CALC cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    div_d    = div_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    is_mod_d = is_mod_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (is_div_c) begin
          zero_d   = (reg2_i == '0);
          is_mod_d = is_mod_c;
          q_neg_d  = a_neg_c ^ b_neg_c;
          r_neg_d  = a_neg_c;
          div_d    = b_neg_c ? neg(reg2_i) : reg2_i;
          cnt_d    = '0;
          if (reg2_i == '0) begin
            quot_d  = '1;
            rem_d   = reg1_i;
            state_d = S_DONE;
          end else begin
            quot_d  = a_neg_c ? neg(reg1_i) : reg1_i;
            rem_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!diff_c[DATA_W]) begin
          rem_d  = diff_c[DATA_W-1:0];
          quot_d = {quot_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d  = trial_c[DATA_W-1:0];
          quot_d = {quot_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      div_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_mod_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      div_q    <= div_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      is_mod_q <= is_mod_d;
      zero_q   <= zero_d;
    end
  end

  assign pause_c = ((state_q == S_IDLE) && is_div_c) || (state_q == S_CALC);

  assign pause_ex         = ~rst & pause_c;
  assign reg_write_data_o = rst ? '0 : result_c;
  assign reg_write_addr_o = rst ? '0 : reg_write_addr_i;
  assign reg_write_en_o   = ~rst & reg_write_en_i & ~pause_c;

endmodule

// File: tb/tb_ex.sv
// Scoreboard bench for the EX stage: driver pushes model results, monitor pops on write-back.
module tb_ex;
  import ex_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [ALU_OP_W-1:0]  aluop;
  logic [ALU_SEL_W-1:0] alusel;
  logic [31:0]          r1, r2;
  logic [4:0]           waddr;
  logic                 wen;
  logic [31:0]          wdata_o;
  logic [4:0]           waddr_o;
  logic                 wen_o;
  logic                 pause_ex;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
  } exp_t;
  exp_t sb[$];

  logic [ALU_OP_W-1:0] ops [19] = '{ALU_OR, ALU_ORI, ALU_AND, ALU_NOR, ALU_XOR,
                                    ALU_SLLW, ALU_SRLW, ALU_SRAW, ALU_ADDW, ALU_SUBW,
                                    ALU_SLT, ALU_SLTU, ALU_MULW, ALU_MULHW, ALU_MULHWU,
                                    ALU_DIVW, ALU_MODW, ALU_DIVWU, ALU_MODWU};

  ex dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush),
    .aluop_i          (aluop),
    .alusel_i         (alusel),
    .reg1_i           (r1),
    .reg2_i           (r2),
    .reg_write_addr_i (waddr),
    .reg_write_en_i   (wen),
    .reg_write_data_o (wdata_o),
    .reg_write_addr_o (waddr_o),
    .reg_write_en_o   (wen_o),
    .pause_ex         (pause_ex)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [ALU_SEL_W-1:0] sel_of(input logic [ALU_OP_W-1:0] op);
    if (op >= ALU_OR && op <= ALU_XOR) return ALU_SEL_LOGIC;
    if (op >= ALU_SLLW && op <= ALU_SRAW) return ALU_SEL_SHIFT;
    return ALU_SEL_ARITH;
  endfunction

  function automatic logic is_div(input logic [ALU_OP_W-1:0] op);
    return op >= ALU_DIVW && op <= ALU_MODWU;
  endfunction

  // Reference: plain 64-bit integer arithmetic on the architectural definitions.
  function automatic logic [31:0] model(input logic [ALU_OP_W-1:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sa, sbv, ua, ub, t;
    logic [63:0] v;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    case (op)
      ALU_OR, ALU_ORI: return a | b;
      ALU_AND:    return a & b;
      ALU_NOR:    return ~(a | b);
      ALU_XOR:    return a ^ b;
      ALU_SLLW:   return a << b[4:0];
      ALU_SRLW:   return a >> b[4:0];
      ALU_SRAW:   begin t = sa >>> b[4:0]; v = t; return v[31:0]; end
      ALU_ADDW:   return a + b;
      ALU_SUBW:   return a - b;
      ALU_SLT:    return (sa < sbv) ? 32'd1 : 32'd0;
      ALU_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
      ALU_MULW:   begin t = sa * sbv; v = t; return v[31:0]; end
      ALU_MULHW:  begin t = sa * sbv; v = t; return v[63:32]; end
      ALU_MULHWU: begin v = {32'd0, a} * {32'd0, b}; return v[63:32]; end
      ALU_DIVW:   begin if (b == 0) return 32'hFFFFFFFF; t = sa / sbv; v = t; return v[31:0]; end
      ALU_MODW:   begin if (b == 0) return a; t = sa % sbv; v = t; return v[31:0]; end
      ALU_DIVWU:  begin if (b == 0) return 32'hFFFFFFFF; t = ua / ub; v = t; return v[31:0]; end
      ALU_MODWU:  begin if (b == 0) return a; t = ua % ub; v = t; return v[31:0]; end
      default:    return 32'd0;
    endcase
  endfunction

  task automatic apply(input logic [ALU_OP_W-1:0] op, input logic [ALU_SEL_W-1:0] sel,
                       input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    flush  = 1'b0;
    aluop  = op;
    alusel = sel;
    r1     = a;
    r2     = b;
    waddr  = 5'($urandom);
    wen    = 1'b1;
  endtask

  task automatic wait_pause(input int exp_pause);
    int n;
    n = 0;
    @(negedge clk);
    while (pause_ex && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("pause_cycles", 32'(n), 32'(exp_pause));
  endtask

  task automatic issue_sel(input logic [ALU_OP_W-1:0] op, input logic [ALU_SEL_W-1:0] sel,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int p;
    apply(op, sel, a, b);
    sb.push_back('{exp, waddr});
    p = !is_div(op) ? 0 : (b == 0 ? 1 : 33);
    wait_pause(p);
  endtask

  task automatic issue(input logic [ALU_OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
    issue_sel(op, sel_of(op), a, b, model(op, a, b));
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    wen   = 1'b0;
    aluop = ALU_NOP;
    alusel = ALU_SEL_NOP;
  endtask

  // Monitor: every write-back must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && wen_o) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wb: got 0x%08h expected no write-back", wdata_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_data", wdata_o, e.data);
        check("wb_addr", 32'(waddr_o), 32'(e.addr));
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; aluop = ALU_ADDW; alusel = ALU_SEL_ARITH;
    r1 = 32'h11; r2 = 32'h22; waddr = 5'd7; wen = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_data", wdata_o, 32'd0);
    check("rst_addr", 32'(waddr_o), 32'd0);
    check("rst_en", 32'(wen_o), 32'd0);
    check("rst_pause", 32'(pause_ex), 32'd0);

    issue_sel(ALU_ADDW, ALU_SEL_ARITH, 32'h7FFFFFFF, 32'd1, 32'h80000000);
    issue_sel(ALU_SLT, ALU_SEL_ARITH, 32'hFFFFFFFF, 32'd1, 32'd1);
    issue_sel(ALU_SLTU, ALU_SEL_ARITH, 32'hFFFFFFFF, 32'd1, 32'd0);
    issue_sel(ALU_MULHW, ALU_SEL_ARITH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);
    issue_sel(ALU_MULHWU, ALU_SEL_ARITH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    issue_sel(ALU_SRAW, ALU_SEL_SHIFT, 32'h80000000, 32'd4, 32'hF8000000);
    issue_sel(ALU_ADDW, ALU_SEL_NOP, 32'd5, 32'd6, 32'd0);
    issue_sel(ALU_ADDW, 3'd6, 32'd5, 32'd6, 32'd0);

    issue_sel(ALU_DIVW, ALU_SEL_ARITH, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    issue_sel(ALU_MODW, ALU_SEL_ARITH, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    issue_sel(ALU_DIVWU, ALU_SEL_ARITH, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC);
    issue_sel(ALU_DIVW, ALU_SEL_ARITH, 32'h12345678, 32'd0, 32'hFFFFFFFF);
    issue_sel(ALU_MODWU, ALU_SEL_ARITH, 32'h12345678, 32'd0, 32'h12345678);
    issue_sel(ALU_DIVW, ALU_SEL_ARITH, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    issue_sel(ALU_MODW, ALU_SEL_ARITH, 32'h80000000, 32'hFFFFFFFF, 32'd0);

    // Flush at CALC iteration 10, then a single-cycle OR.
    apply(ALU_DIVW, ALU_SEL_ARITH, 32'd1000, 32'd7);
    repeat (11) @(negedge clk);
    check("pause_mid_calc", 32'(pause_ex), 32'd1);
    @(posedge clk);
    #1 flush = 1'b1;
    issue_sel(ALU_OR, ALU_SEL_LOGIC, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0);

    issue_sel(ALU_MODWU, ALU_SEL_ARITH, 32'd100, 32'd7, 32'd2);
    issue_sel(ALU_MODWU, ALU_SEL_ARITH, 32'd9, 32'd3, 32'd0);

    // Reset in the middle of CALC.
    apply(ALU_DIVWU, ALU_SEL_ARITH, 32'd12345, 32'd11);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_data", wdata_o, 32'd0);
    check("midrst_addr", 32'(waddr_o), 32'd0);
    check("midrst_en", 32'(wen_o), 32'd0);
    check("midrst_pause", 32'(pause_ex), 32'd0);
    issue_sel(ALU_XOR, ALU_SEL_LOGIC, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555);

    for (int i = 0; i < 60; i++) begin
      logic [ALU_OP_W-1:0] op;
      logic [31:0] a, b;
      op = ops[$urandom_range(0, 18)];
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom);
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 40));
        2:       b = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: b = 32'($urandom);
      endcase
      issue(op, a, b);
    end

    go_idle();
    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
